output_pio: RTL and testbench

OUTPUT_PIO -- requirements
Module: output_pio

---
 rtl/output_pio.sv | 146 ++++++++++++++
 tb/tb_output_pio.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/output_pio.sv
// Memory-mapped output PIO: DATA register with set/clear/toggle aliases and a
// timed one-shot pulse mask XORed onto a registered external port.
module output_pio #(
    parameter int          PORT_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int          PULSE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    output logic [PORT_WIDTH-1:0] port
);

    typedef enum logic [2:0] {
        OFF_DATA   = 3'd0,
        OFF_SET    = 3'd1,
        OFF_CLEAR  = 3'd2,
        OFF_TOGGLE = 3'd3,
        OFF_PULSE  = 3'd4,
        OFF_STATUS = 3'd5,
        OFF_RSV6   = 3'd6,
        OFF_RSV7   = 3'd7
    } off_e;

    localparam logic [PORT_WIDTH-1:0] RST_V    = RESET_VALUE[PORT_WIDTH-1:0];
    localparam logic [15:0]           PULSE_LD = 16'(PULSE_CYCLES);

    off_e                  off;
    logic [31:0]           wmask32;
    logic [31:0]           lane32;
    logic [PORT_WIDTH-1:0] wmask;
    logic [PORT_WIDTH-1:0] lane;

    logic [PORT_WIDTH-1:0] data_q, data_d;
    logic [PORT_WIDTH-1:0] pulse_mask_q, pulse_mask_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [PORT_WIDTH-1:0] port_q, port_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  readdatavalid_q, readdatavalid_d;

    assign off = off_e'(address[2:0]);

    // Upper address bits and out-of-port mask bits are deliberately ignored.
    generate
        if (ADDR_WIDTH > 3) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_WIDTH-1:3];
        end
        if (PORT_WIDTH < 32) begin : g_mask_hi
            logic unused_mask_hi;
            assign unused_mask_hi = ^{wmask32[31:PORT_WIDTH], lane32[31:PORT_WIDTH]};
        end
    endgenerate

    always_comb begin
        wmask32 = '0;
        lane32  = '0;
        for (int i = 0; i < 4; i++) begin
            lane32[8*i +: 8]  = {8{byteenable[i]}};
            wmask32[8*i +: 8] = byteenable[i] ? writedata[8*i +: 8] : 8'h00;
        end
        wmask = wmask32[PORT_WIDTH-1:0];
        lane  = lane32[PORT_WIDTH-1:0];
    end

    // Register update. The write decode runs after the countdown so a PULSE
    // write landing on the expiry edge wins and restarts the pulse.
    always_comb begin
        data_d       = data_q;
        pulse_mask_d = pulse_mask_q;
        cnt_d        = cnt_q;

        if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                pulse_mask_d = '0;
            end
        end

        if (write) begin
            case (off)
                OFF_DATA:   data_d = (data_q & ~lane) | wmask;
                OFF_SET:    data_d = data_q | wmask;
                OFF_CLEAR:  data_d = data_q & ~wmask;
                OFF_TOGGLE: data_d = data_q ^ wmask;
                OFF_PULSE: begin
                    if (|wmask) begin
                        pulse_mask_d = wmask;
                        cnt_d        = PULSE_LD;
                    end else begin
                        pulse_mask_d = '0;
                        cnt_d        = '0;
                    end
                end
                default: ;
            endcase
        end

        port_d = data_d ^ pulse_mask_d;
    end

    // Reads sample the current (pre-write) register state.
    always_comb begin
        readdata_d      = readdata_q;
        readdatavalid_d = read;
        if (read) begin
            readdata_d = '0;
            case (off)
                OFF_DATA:   readdata_d[PORT_WIDTH-1:0] = data_q;
                OFF_PULSE:  readdata_d[PORT_WIDTH-1:0] = pulse_mask_q;
                OFF_STATUS: readdata_d[0]              = (cnt_q != 16'd0);
                default:    readdata_d                 = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q          <= RST_V;
            pulse_mask_q    <= '0;
            cnt_q           <= '0;
            port_q          <= RST_V;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            data_q          <= data_d;
            pulse_mask_q    <= pulse_mask_d;
            cnt_q           <= cnt_d;
            port_q          <= port_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign port          = port_q;
    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_output_pio.sv
// Directed bench for output_pio: register aliases, byte lanes, pulse timing,
// read/write collision and asynchronous reset.
module tb_output_pio;

    localparam int          PW  = 32;
    localparam logic [31:0] RV  = 32'h0000_1234;
    localparam int          PC  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   address = '0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [3:0]    byteenable = '0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic [PW-1:0] port;

    int checks = 0;
    int failures = 0;

    output_pio #(
        .PORT_WIDTH(PW), .ADDR_WIDTH(32), .RESET_VALUE(RV), .PULSE_CYCLES(PC)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .byteenable(byteenable), .read(read),
        .readdata(readdata), .readdatavalid(readdatavalid), .port(port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = {29'd0, a}; writedata = d; byteenable = be; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = {29'd0, a}; read = 1'b1;
        tick();
        read = 1'b0;
        chk({tag, "_vld"}, {31'd0, readdatavalid}, 32'd1);
        chk(tag, readdata, exp);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_port", port, RV);
        chk("rst_rdv", {31'd0, readdatavalid}, 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        reset = 1'b1;
        rd("rst_read_data", 3'd0, RV);
        tick();
        chk("rdv_drop", {31'd0, readdatavalid}, 32'd0);
        chk("rdata_hold", readdata, RV);

        // SET / CLEAR / TOGGLE from DATA=0
        wr(3'd0, 32'h0, 4'hF);
        chk("data_zero", port, 32'h0);
        wr(3'd1, 32'h0000_00F0, 4'hF);
        chk("set", port, 32'h0000_00F0);
        wr(3'd2, 32'h0000_0030, 4'hF);
        chk("clear", port, 32'h0000_00C0);
        wr(3'd3, 32'h0000_0101, 4'hF);
        chk("toggle", port, 32'h0000_01C1);
        rd("alias_read0", 3'd1, 32'h0);
        rd("alias_read3", 3'd3, 32'h0);

        // Byte lanes
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd0, 32'hAABB_CCDD, 4'b0101);
        chk("be_port", port, 32'h00BB_00DD);
        rd("be_read", 3'd0, 32'h00BB_00DD);
        wr(3'd1, 32'hFF00_0000, 4'b0111);
        chk("set_be_masked", port, 32'h00BB_00DD);

        // Reserved offsets
        wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        chk("rsv_write", port, 32'h00BB_00DD);
        rd("rsv_read6", 3'd6, 32'h0);

        // Pulse length and busy, DATA=0
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd4, 32'h1, 4'hF);
        chk("pulse_p0", port, 32'h1);
        address = 32'd5; read = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("pulse_busy%0d", k), readdata, (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("pulse_port%0d", k), port, (k <= 3) ? 32'h1 : 32'h0);
        end
        read = 1'b0;

        // Restart at cycle 2
        wr(3'd4, 32'h1, 4'hF);
        chk("rs_p0", port, 32'h1);
        tick();
        chk("rs_p1", port, 32'h1);
        wr(3'd4, 32'h2, 4'hF);
        chk("rs_new0", port, 32'h2);
        rd("rs_mask", 3'd4, 32'h2);
        tick();
        chk("rs_new2", port, 32'h2);
        tick();
        chk("rs_new3", port, 32'h2);
        tick();
        chk("rs_end", port, 32'h0);

        // Zero-mask pulse write cancels immediately
        wr(3'd4, 32'h10, 4'hF);
        chk("cancel_on", port, 32'h10);
        wr(3'd4, 32'h0, 4'hF);
        chk("cancel_port", port, 32'h0);
        rd("cancel_busy", 3'd5, 32'h0);

        // Read and write collide
        wr(3'd0, 32'h5, 4'hF);
        address = 32'd0; writedata = 32'hA; byteenable = 4'hF; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        chk("rw_old", readdata, 32'h5);
        chk("rw_port", port, 32'hA);
        rd("rw_new", 3'd0, 32'hA);

        // Asynchronous reset mid-pulse
        wr(3'd4, 32'h1, 4'hF);
        chk("ar_pulse", port, 32'hB);
        #2 reset = 1'b0;
        #1;
        chk("ar_port", port, RV);
        chk("ar_rdv", {31'd0, readdatavalid}, 32'd0);
        tick();
        reset = 1'b1;
        rd("ar_busy", 3'd5, 32'h0);
        chk("ar_port_after", port, RV);
        rd("ar_mask", 3'd4, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
